// File: rtl/line_pkg.sv
// Shared definitions for the line rasteriser.
// Holds coordinate, colour and error widths, the FSM state encoding,
// the screen size and a small absolute-difference helper.
package line_pkg;
  localparam int XW = 9;   // x coordinate width
  localparam int YW = 8;   // y coordinate width
  localparam int CW = 3;   // colour width
  localparam int WW = 9;   // working coordinate width, after the steep swap
  localparam int EW = 11;  // signed Bresenham error width

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  function automatic logic [WW-1:0] abs_diff(input logic [WW-1:0] a, input logic [WW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/line_if.sv
// Line-drawing handshake and framebuffer write bundle.
//   master: controller side; drives go/colour/endpoints, sees done and the pixel stream
//   slave : rasteriser side; receives the request, drives done/plot/plot_x/plot_y/plot_colour
interface line_if;
  import line_pkg::*;

  logic          go;
  logic [CW-1:0] colour;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic          done;
  logic          plot;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;
  logic [CW-1:0] plot_colour;

  modport master (
    output go, colour, x0, x1, y0, y1,
    input  done, plot, plot_x, plot_y, plot_colour
  );

  modport slave (
    input  go, colour, x0, x1, y0, y1,
    output done, plot, plot_x, plot_y, plot_colour
  );
endinterface

// File: rtl/line_setup.sv
// Combinational line setup: steep detect, x/y swap, left-to-right ordering,
// dx, dy, y step direction and the initial Bresenham error.
//   x0,y0,x1,y1 : captured endpoints, 9-bit working width
//   steep       : |dy| > |dx|; coordinates below are in the swapped domain
//   sx0,sy0,sx1 : start point and final x after ordering
//   dx,dy       : step counts along major and minor axis
//   ystep_neg   : minor axis decrements
//   err0        : -(dx>>1)
module line_setup
  import line_pkg::*;
(
  input  logic [WW-1:0]        x0,
  input  logic [WW-1:0]        y0,
  input  logic [WW-1:0]        x1,
  input  logic [WW-1:0]        y1,
  output logic                 steep,
  output logic [WW-1:0]        sx0,
  output logic [WW-1:0]        sy0,
  output logic [WW-1:0]        sx1,
  output logic [WW-1:0]        dx,
  output logic [WW-1:0]        dy,
  output logic                 ystep_neg,
  output logic signed [EW-1:0] err0
);
  logic [WW-1:0] ax0, ay0, ax1, ay1;
  logic [WW-1:0] sy1;
  logic [WW-1:0] half_dx;

  assign steep = abs_diff(y1, y0) > abs_diff(x1, x0);

  always_comb begin
    ax0 = steep ? y0 : x0;
    ay0 = steep ? x0 : y0;
    ax1 = steep ? y1 : x1;
    ay1 = steep ? x1 : y1;
    sx0 = ax0;
    sy0 = ay0;
    sx1 = ax1;
    sy1 = ay1;
    if (ax0 > ax1) begin
      sx0 = ax1;
      sy0 = ay1;
      sx1 = ax0;
      sy1 = ay0;
    end
  end

  assign dx        = sx1 - sx0;
  assign dy        = abs_diff(sy1, sy0);
  assign ystep_neg = sy0 > sy1;
  assign half_dx   = dx >> 1;
  assign err0      = -$signed({{(EW-WW){1'b0}}, half_dx});
endmodule

// File: rtl/line_engine.sv
// Bresenham line rasteriser, responder side of the go/done handshake.
// Captures a line request, emits one pixel per clock, then holds done
// until go is released.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : line_if slave (request in, done + pixel write stream out)
//
// state | meaning
// IDLE  | waiting for go; endpoints and colour captured on go
// SETUP | one cycle; registers line_setup results
// DRAW  | one pixel per cycle until the major axis reaches its end
// DONE  | done asserted; leaves for IDLE once go is seen low
module line_engine
  import line_pkg::*;
(
  input logic   clock,
  input logic   reset,
  line_if.slave bus
);
  state_t               state_q, state_d;
  logic [CW-1:0]        colour_q, colour_d;
  logic [WW-1:0]        ex0_q, ex0_d, ey0_q, ey0_d, ex1_q, ex1_d, ey1_q, ey1_d;
  logic                 steep_q, steep_d;
  logic [WW-1:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d, x_end_q, x_end_d;
  logic [WW-1:0]        dx_q, dx_d, dy_q, dy_d;
  logic                 ystep_neg_q, ystep_neg_d;
  logic signed [EW-1:0] err_q, err_d;
  logic                 done_q, done_d, plot_q, plot_d;
  logic [XW-1:0]        plot_x_q, plot_x_d;
  logic [YW-1:0]        plot_y_q, plot_y_d;
  logic [CW-1:0]        plot_colour_q, plot_colour_d;

  logic                 s_steep, s_ystep_neg;
  logic [WW-1:0]        s_x0, s_y0, s_x1, s_dx, s_dy;
  logic signed [EW-1:0] s_err0;
  logic signed [EW-1:0] err_step;

  line_setup u_setup (
    .x0(ex0_q), .y0(ey0_q), .x1(ex1_q), .y1(ey1_q),
    .steep(s_steep), .sx0(s_x0), .sy0(s_y0), .sx1(s_x1),
    .dx(s_dx), .dy(s_dy), .ystep_neg(s_ystep_neg), .err0(s_err0)
  );

  assign err_step = err_q + $signed({{(EW-WW){1'b0}}, dy_q});

  always_comb begin
    state_d       = state_q;
    colour_d      = colour_q;
    ex0_d         = ex0_q;
    ey0_d         = ey0_q;
    ex1_d         = ex1_q;
    ey1_d         = ey1_q;
    steep_d       = steep_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    x_end_d       = x_end_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    ystep_neg_d   = ystep_neg_q;
    err_d         = err_q;
    done_d        = done_q;
    plot_d        = 1'b0;
    plot_x_d      = plot_x_q;
    plot_y_d      = plot_y_q;
    plot_colour_d = plot_colour_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.go) begin
          colour_d = bus.colour;
          ex0_d    = bus.x0;
          ex1_d    = bus.x1;
          ey0_d    = {{(WW-YW){1'b0}}, bus.y0};
          ey1_d    = {{(WW-YW){1'b0}}, bus.y1};
          state_d  = SETUP;
        end
      end
      SETUP: begin
        steep_d     = s_steep;
        cur_x_d     = s_x0;
        cur_y_d     = s_y0;
        x_end_d     = s_x1;
        dx_d        = s_dx;
        dy_d        = s_dy;
        ystep_neg_d = s_ystep_neg;
        err_d       = s_err0;
        state_d     = DRAW;
      end
      DRAW: begin
        plot_d        = 1'b1;
        plot_x_d      = steep_q ? cur_y_q : cur_x_q;
        plot_y_d      = steep_q ? cur_x_q[YW-1:0] : cur_y_q[YW-1:0];
        plot_colour_d = colour_q;
        // strictly positive error moves the minor axis
        if (!err_step[EW-1] && (err_step != '0)) begin
          cur_y_d = ystep_neg_q ? (cur_y_q - 1'b1) : (cur_y_q + 1'b1);
          err_d   = err_step - $signed({{(EW-WW){1'b0}}, dx_q});
        end else begin
          err_d = err_step;
        end
        cur_x_d = cur_x_q + 1'b1;
        if (cur_x_q == x_end_q) state_d = DONE;
      end
      DONE: begin
        // first DONE cycle always raises done, so a go dropped mid-line still sees a pulse
        if (!done_q) begin
          done_d = 1'b1;
        end else if (!bus.go) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      colour_q      <= '0;
      ex0_q         <= '0;
      ey0_q         <= '0;
      ex1_q         <= '0;
      ey1_q         <= '0;
      steep_q       <= 1'b0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      x_end_q       <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      ystep_neg_q   <= 1'b0;
      err_q         <= '0;
      done_q        <= 1'b0;
      plot_q        <= 1'b0;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
    end else begin
      state_q       <= state_d;
      colour_q      <= colour_d;
      ex0_q         <= ex0_d;
      ey0_q         <= ey0_d;
      ex1_q         <= ex1_d;
      ey1_q         <= ey1_d;
      steep_q       <= steep_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      x_end_q       <= x_end_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      ystep_neg_q   <= ystep_neg_d;
      err_q         <= err_d;
      done_q        <= done_d;
      plot_q        <= plot_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.plot        = plot_q;
  assign bus.plot_x      = plot_x_q;
  assign bus.plot_y      = plot_y_q;
  assign bus.plot_colour = plot_colour_q;
endmodule

// File: tb/tb_line_engine.sv
// Self-checking bench for line_engine: expected pixels are queued when a
// line is requested and popped as plot strobes appear.
module tb_line_engine;
  logic clock = 1'b0;
  logic reset;

  line_if bus ();

  line_engine u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [19:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] pix(input int x, input int y, input int c);
    logic [8:0] xv;
    logic [7:0] yv;
    logic [2:0] cv;
    xv = x[8:0];
    yv = y[7:0];
    cv = c[2:0];
    return {xv, yv, cv};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference Bresenham on plain integers
  task automatic push_model(input int x0, input int y0, input int x1, input int y1, input int c);
    int ax0, ay0, ax1, ay1, t, dx, dy, ys, err, y;
    bit steep;
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    ax0 = steep ? y0 : x0; ay0 = steep ? x0 : y0;
    ax1 = steep ? y1 : x1; ay1 = steep ? x1 : y1;
    if (ax0 > ax1) begin
      t = ax0; ax0 = ax1; ax1 = t;
      t = ay0; ay0 = ay1; ay1 = t;
    end
    dx = ax1 - ax0;
    dy = iabs(ay1 - ay0);
    ys = (ay0 < ay1) ? 1 : -1;
    err = -(dx / 2);
    y = ay0;
    for (int x = ax0; x <= ax1; x++) begin
      if (err < -1024 || err > 1023) check("err_range", 1, 0);
      sb_q.push_back(steep ? pix(y, x, c) : pix(x, y, c));
      err = err + dy;
      if (err > 0) begin
        y = y + ys;
        err = err - dx;
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.plot === 1'b1) begin
      if (sb_q.size() == 0) check("plot_extra", 1, 0);
      else check("pixel", {12'd0, bus.plot_x, bus.plot_y, bus.plot_colour}, {12'd0, sb_q.pop_front()});
    end
  end

  task automatic run_line(input int x0, input int y0, input int x1, input int y1, input int c,
                          input bit hold, input bit use_model);
    int npix, cnt, first, last, nplot;
    npix = ((iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1;
    if (use_model) push_model(x0, y0, x1, y1, c);
    @(negedge clock);
    bus.x0 = x0[8:0]; bus.y0 = y0[7:0]; bus.x1 = x1[8:0]; bus.y1 = y1[7:0];
    bus.colour = c[2:0];
    bus.go = 1'b1;
    cnt = 0; first = -1; last = -1; nplot = 0;
    while (bus.done !== 1'b1 && cnt < npix + 20) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) begin
        // request already captured; later input changes must not matter
        bus.x0 = 9'($urandom); bus.x1 = 9'($urandom);
        bus.y0 = 8'($urandom); bus.y1 = 8'($urandom);
        bus.colour = 3'($urandom);
        if (!hold) bus.go = 1'b0;
      end
      if (bus.plot === 1'b1) begin
        nplot++;
        if (first < 0) first = cnt;
        last = cnt;
      end
    end
    check("done_latency", cnt, npix + 3);
    check("first_plot", first, 3);
    check("plot_count", nplot, npix);
    check("plot_contig", last - first + 1, npix);
    check("sb_drained", sb_q.size(), 0);
    if (hold) begin
      repeat (3) begin
        @(negedge clock);
        check("done_held", bus.done, 1);
        check("plot_quiet", bus.plot, 0);
      end
      bus.go = 1'b0;
    end
    @(negedge clock);
    check("done_drop", bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.go = 1'b0; bus.colour = '0;
    bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
    reset = 1'b1;
    #1;
    check("rst_done", bus.done, 0);
    check("rst_plot", bus.plot, 0);
    check("rst_px", bus.plot_x, 0);
    check("rst_py", bus.plot_y, 0);
    check("rst_pc", bus.plot_colour, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // shallow line, explicit pixels
    sb_q.push_back(pix(0, 0, 5)); sb_q.push_back(pix(1, 0, 5)); sb_q.push_back(pix(2, 1, 5));
    sb_q.push_back(pix(3, 1, 5)); sb_q.push_back(pix(4, 2, 5));
    run_line(0, 0, 4, 2, 5, 1'b1, 1'b0);

    // reversed endpoints: same pixel order
    sb_q.push_back(pix(0, 0, 5)); sb_q.push_back(pix(1, 0, 5)); sb_q.push_back(pix(2, 1, 5));
    sb_q.push_back(pix(3, 1, 5)); sb_q.push_back(pix(4, 2, 5));
    run_line(4, 2, 0, 0, 5, 1'b1, 1'b0);

    // vertical steep
    for (int y = 5; y <= 8; y++) sb_q.push_back(pix(10, y, 2));
    run_line(10, 5, 10, 8, 2, 1'b1, 1'b0);

    // single point
    sb_q.push_back(pix(7, 7, 7));
    run_line(7, 7, 7, 7, 7, 1'b1, 1'b0);

    // full diagonal, go dropped mid-line so done pulses
    run_line(0, 239, 319, 0, 3, 1'b0, 1'b1);

    // steep reversed and random lines
    run_line(20, 50, 5, 10, 6, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      run_line($urandom_range(0, 319), $urandom_range(0, 239),
               $urandom_range(0, 319), $urandom_range(0, 239),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1);

    // reset in the middle of a line
    push_model(0, 0, 100, 0, 6);
    @(negedge clock);
    bus.x0 = 9'd0; bus.y0 = 8'd0; bus.x1 = 9'd100; bus.y1 = 8'd0; bus.colour = 3'd6;
    bus.go = 1'b1;
    repeat (20) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    bus.go = 1'b0;
    #1;
    check("midrst_plot", bus.plot, 0);
    check("midrst_done", bus.done, 0);
    sb_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("post_rst_plot", bus.plot, 0);
      check("post_rst_done", bus.done, 0);
    end
    run_line(3, 3, 9, 5, 4, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
